// File: rtl/instr_encoder.sv
// instr_encoder: packs ARM-subset requests into 32-bit words and streams them to imem (INSTR_ENC_CHECK_EN enables illegal-request checking)
module instr_encoder #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  BASE_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [3:0]        in_cond,
    input  logic [2:0]        in_op,
    input  logic              in_s,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [3:0]        in_ra,
    input  logic [23:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              err
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word, enc;
    logic [ADDR_W:0]   cnt;
    logic [3:0]        dp_cmd;
    logic [2:0]        mul_f;
    logic              accept, hs, load;
    assign mem_we    = state == BUSY;
    assign in_ready  = !start && (!mem_we || mem_ready);
    assign accept    = in_valid && in_ready;
    assign hs        = mem_we && mem_ready;
    assign mem_addr  = ptr;
    assign mem_wdata = word;
    assign word_cnt  = cnt;
`ifdef INSTR_ENC_CHECK_EN
    logic bad, err_q;
    assign bad  = in_class[2] && in_class[1]
               || (in_class == 3'd0 || in_class == 3'd1) && in_op > 3'd3
               || in_class == 3'd2 && in_op > 3'd2
               || in_class == 3'd1 && in_imm[23:8] != '0
               || (in_class == 3'd3 || in_class == 3'd4) && in_imm[23:12] != '0;
    assign load = accept && !bad;
    assign err  = err_q;
`else
    assign load = accept;
    assign err  = 1'b0;
`endif
    always_comb begin
        dp_cmd = in_op[1:0] == 2'd0 ? 4'b0100 :
                 in_op[1:0] == 2'd1 ? 4'b0010 :
                 in_op[1:0] == 2'd2 ? 4'b0000 : 4'b1100;
        mul_f  = {|in_op, in_op[1], 1'b0};
        enc    = in_class == 3'd0 ? {in_cond, 3'b000, dp_cmd, in_s, in_rn, in_rd, 8'h00, in_rm} :
                 in_class == 3'd1 ? {in_cond, 3'b001, dp_cmd, in_s, in_rn, in_rd, 4'h0, in_imm[7:0]} :
                 in_class == 3'd2 ? {in_cond, 4'b0000, mul_f, in_s, in_rd, in_ra, in_rm, 4'b1001, in_rn} :
                 in_class == 3'd3 ? {in_cond, 7'b0101100, 1'b1, in_rn, in_rd, in_imm[11:0]} :
                 in_class == 3'd4 ? {in_cond, 7'b0101100, 1'b0, in_rn, in_rd, in_imm[11:0]} :
                 in_class == 3'd5 ? {in_cond, 4'b1010, in_imm} : 32'h0;
    end
    always_comb begin
        state_nx = load ? BUSY : hs ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset || start)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= BASE_RST;
            word <= '0;
            cnt  <= '0;
`ifdef INSTR_ENC_CHECK_EN
            err_q <= 1'b0;
`endif
        end else if (start) begin
            ptr <= start_addr;
            cnt <= '0;
`ifdef INSTR_ENC_CHECK_EN
            err_q <= 1'b0;
`endif
        end else begin
            if (hs) begin
                ptr <= ptr + 1'b1;
                cnt <= &cnt ? cnt : cnt + 1'b1;
            end
            if (load)
                word <= enc;
`ifdef INSTR_ENC_CHECK_EN
            if (accept && bad)
                err_q <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed table-driven bench for instr_encoder plus stall/start/wrap/reset sequences
module tb_instr_encoder;
    typedef struct {
        logic [2:0]  cls;
        logic [3:0]  cond;
        logic [2:0]  op;
        logic        s;
        logic [3:0]  rd, rn, rm, ra;
        logic [23:0] imm;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 0, reset = 1, start = 0, in_valid = 0, mem_ready = 1;
    logic [7:0]  start_addr = 0;
    logic        in_ready, in_s = 0, mem_we, err;
    logic [2:0]  in_class = 0, in_op = 0;
    logic [3:0]  in_cond = 0, in_rd = 0, in_rn = 0, in_rm = 0, in_ra = 0;
    logic [23:0] in_imm = 0;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_cnt;
    int          nvec = 0, nfail = 0, ea = 0, ec = 0;
    vec_t        vt[8];

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_cond(in_cond),
        .in_op(in_op), .in_s(in_s), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_ra(in_ra),
        .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_cnt(word_cnt), .err(err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [2:0] cls, logic [3:0] cond, logic [2:0] op, logic s,
                                logic [3:0] rd, logic [3:0] rn, logic [3:0] rm, logic [3:0] ra,
                                logic [23:0] imm, logic [31:0] exp);
        vec_t v;
        v.cls = cls; v.cond = cond; v.op = op; v.s = s;
        v.rd = rd; v.rn = rn; v.rm = rm; v.ra = ra; v.imm = imm; v.exp = exp;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_class = v.cls; in_cond = v.cond; in_op = v.op; in_s = v.s;
        in_rd = v.rd; in_rn = v.rn; in_rm = v.rm; in_ra = v.ra; in_imm = v.imm;
        in_valid = 1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] a);
        start = 1;
        start_addr = a;
        #1;
        chk("in_ready_in_start", {31'b0, in_ready}, 32'h0);
        step();
        start = 0;
    endtask

    initial begin
        vec_t a, b, c;
        vt[0] = mk(3'd0, 4'hE, 3'd0, 0, 4'd2, 4'd3, 4'd4, 4'd0, 24'h0,      32'hE0832004);
        vt[1] = mk(3'd0, 4'h0, 3'd2, 1, 4'd1, 4'd2, 4'd3, 4'd0, 24'h0,      32'h00121003);
        vt[2] = mk(3'd1, 4'h1, 3'd3, 0, 4'd4, 4'd5, 4'd0, 4'd0, 24'hFF,     32'h138540FF);
        vt[3] = mk(3'd2, 4'hE, 3'd0, 0, 4'd3, 4'd1, 4'd2, 4'd0, 24'h0,      32'hE0030291);
        vt[4] = mk(3'd2, 4'hE, 3'd2, 1, 4'd9, 4'd6, 4'd7, 4'd8, 24'h0,      32'hE0D98796);
        vt[5] = mk(3'd4, 4'hE, 3'd0, 0, 4'd1, 4'd2, 4'd0, 4'd0, 24'hABC,    32'hE5821ABC);
        vt[6] = mk(3'd5, 4'h0, 3'd0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h123456, 32'h0A123456);
        vt[7] = mk(3'd0, 4'h2, 3'd1, 0, 4'hF, 4'hE, 4'hD, 4'd0, 24'h0,      32'h204EF00D);

        step(); step();
        reset = 0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_addr", {24'b0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_cnt", {23'b0, word_cnt}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            drive(vt[i]);
            step();
            in_valid = 0;
            chk($sformatf("vec%0d_we", i), {31'b0, mem_we}, 32'h1);
            chk($sformatf("vec%0d_addr", i), {24'b0, mem_addr}, ea);
            chk($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].exp);
            step();
            ea = (ea + 1) % 256;
            ec++;
            chk($sformatf("vec%0d_idle", i), {31'b0, mem_we}, 32'h0);
            chk($sformatf("vec%0d_cnt", i), {23'b0, word_cnt}, ec);
        end

        pulse_start(8'd0);
        chk("start_cnt_clear", {23'b0, word_cnt}, 32'h0);
        a = mk(3'd1, 4'hE, 3'd1, 1, 4'd1, 4'd1, 4'd0, 4'd0, 24'h5, 32'hE2511005);
        b = mk(3'd3, 4'hE, 3'd0, 0, 4'd5, 4'd0, 4'd0, 4'd0, 24'h10, 32'hE5905010);
        c = mk(3'd5, 4'hE, 3'd0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, 32'hEAFFFFFE);
        drive(a); step();
        chk("b2b0_addr", {24'b0, mem_addr}, 32'd0);
        chk("b2b0_wdata", mem_wdata, a.exp);
        chk("b2b0_in_ready", {31'b0, in_ready}, 32'h1);
        drive(b); step();
        chk("b2b1_addr", {24'b0, mem_addr}, 32'd1);
        chk("b2b1_wdata", mem_wdata, b.exp);
        drive(c); step();
        chk("b2b2_addr", {24'b0, mem_addr}, 32'd2);
        chk("b2b2_wdata", mem_wdata, c.exp);
        chk("b2b2_we", {31'b0, mem_we}, 32'h1);
        in_valid = 0; step();
        chk("b2b_idle", {31'b0, mem_we}, 32'h0);
        chk("b2b_cnt", {23'b0, word_cnt}, 32'd3);

        mem_ready = 0;
        drive(mk(3'd2, 4'hE, 3'd1, 0, 4'd7, 4'd1, 4'd2, 4'd6, 24'h0, 32'hE0876291));
        step();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", i), {31'b0, in_ready}, 32'h0);
            chk($sformatf("stall%0d_we", i), {31'b0, mem_we}, 32'h1);
            chk($sformatf("stall%0d_addr", i), {24'b0, mem_addr}, 32'd3);
            chk($sformatf("stall%0d_wdata", i), mem_wdata, 32'hE0876291);
            step();
        end
        mem_ready = 1;
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 32'h1);
        step();
        chk("release_idle", {31'b0, mem_we}, 32'h0);
        chk("release_addr", {24'b0, mem_addr}, 32'd4);
        chk("release_cnt", {23'b0, word_cnt}, 32'd4);

        pulse_start(8'hFF);
        a = mk(3'd4, 4'hE, 3'd0, 0, 4'd1, 4'd2, 4'd0, 4'd0, 24'h4, 32'hE5821004);
        drive(a); step();
        chk("wrap0_addr", {24'b0, mem_addr}, 32'hFF);
        chk("wrap0_wdata", mem_wdata, a.exp);
        step();
        in_valid = 0;
        chk("wrap1_addr", {24'b0, mem_addr}, 32'h0);
        chk("wrap1_we", {31'b0, mem_we}, 32'h1);
        step();
        chk("wrap_cnt", {23'b0, word_cnt}, 32'd2);

`ifdef INSTR_ENC_CHECK_EN
        drive(mk(3'd1, 4'hE, 3'd0, 0, 4'd1, 4'd1, 4'd0, 4'd0, 24'h100, 32'h0));
        step();
        in_valid = 0;
        chk("illegal_we", {31'b0, mem_we}, 32'h0);
        chk("illegal_err", {31'b0, err}, 32'h1);
        chk("illegal_cnt", {23'b0, word_cnt}, 32'd2);
        pulse_start(8'd0);
        chk("start_clears_err", {31'b0, err}, 32'h0);
`else
        drive(mk(3'd6, 4'hE, 3'd0, 1, 4'd1, 4'd1, 4'd1, 4'd1, 24'h1, 32'h0));
        step();
        in_valid = 0;
        chk("cls6_we", {31'b0, mem_we}, 32'h1);
        chk("cls6_wdata", mem_wdata, 32'h0);
        chk("cls6_err", {31'b0, err}, 32'h0);
        step();
        drive(mk(3'd1, 4'hE, 3'd1, 1, 4'd1, 4'd1, 4'd0, 4'd0, 24'h1FF, 32'hE25110FF));
        step();
        in_valid = 0;
        chk("trunc_wdata", mem_wdata, 32'hE25110FF);
        chk("trunc_err", {31'b0, err}, 32'h0);
        step();
        pulse_start(8'd0);
`endif

        drive(vt[6]);
        for (int i = 0; i < 520; i++) step();
        in_valid = 0;
        step();
        chk("sat_cnt", {23'b0, word_cnt}, 32'd511);
        chk("sat_addr", {24'b0, mem_addr}, 32'd8);

        mem_ready = 0;
        drive(vt[0]); step();
        in_valid = 0;
        chk("pend_we", {31'b0, mem_we}, 32'h1);
        pulse_start(8'h40);
        chk("start_drop_we", {31'b0, mem_we}, 32'h0);
        chk("start_drop_addr", {24'b0, mem_addr}, 32'h40);
        chk("start_drop_cnt", {23'b0, word_cnt}, 32'h0);

        drive(vt[1]); step();
        in_valid = 0;
        chk("pend2_addr", {24'b0, mem_addr}, 32'h40);
        reset = 1; step(); reset = 0;
        chk("rst_drop_we", {31'b0, mem_we}, 32'h0);
        chk("rst_drop_addr", {24'b0, mem_addr}, 32'h0);
        chk("rst_drop_wdata", mem_wdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming ARM-subset instruction encoder. It takes field-level instruction requests and packs each into a 32-bit machine word in exactly the format the control decoder expects. It then writes the words sequentially into instruction memory through a backpressured write port. It sits between the testbench/boot loader and imem, and is the program-load path that feeds the single-cycle and multicycle cores.

## Interface
Parameters:
- ADDR_W, 8: word-address width of the imem write port; the address wraps at 2^ADDR_W words.
- BASE_RST, 0: word address loaded at reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; loads the write pointer from start_addr and clears counters.
- start_addr  in  ADDR_W  word address used by start.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_class  in  3  0=DP-reg, 1=DP-imm, 2=MUL, 3=LDR, 4=STR, 5=B; 6 and 7 are illegal.
- in_cond  in  4  condition field.
- in_op  in  3  DP: 0=ADD, 1=SUB, 2=AND, 3=ORR. MUL: 0=MUL, 1=UMULL, 2=SMULL.
- in_s  in  1  set-flags bit.
- in_rd, in_rn, in_rm, in_ra  in  4 each  register fields.
- in_imm  in  24  immediate: imm8 for DP-imm, imm12 for LDR/STR, imm24 for B.
- mem_we  out  1  write request; held until accepted.
- mem_ready  in  1  imem accepts the write this cycle.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded word.
- word_cnt  out  ADDR_W+1  number of words written since start/reset; saturates.
- err  out  1  sticky; set on an illegal request, cleared by start/reset.

## Operation
- Encoding, with bits [31:28]=cond for every class:
  - DP-reg: [27:26]=00, [25]=0, [24:21]=cmd (ADD 0100, SUB 0010, AND 0000, ORR 1100), [20]=S, [19:16]=Rn, [15:12]=Rd, [11:4]=0, [3:0]=Rm.
  - DP-imm: same as DP-reg but [25]=1, [11:8]=0 (rot), [7:0]=imm[7:0].
  - MUL: [27:24]=0000, [23:21]=000/100/110 for MUL/UMULL/SMULL, [20]=S, [19:16]=Rd (RdHi for the long forms), [15:12]=Ra (RdLo for the long forms), [11:8]=Rm, [7:4]=1001, [3:0]=Rn.
  - LDR/STR: [27:26]=01, [25]=0 (immediate offset), [24:21]=1100 (P=1, U=1, B=0, W=0), [20]=1 for LDR and 0 for STR, [19:16]=Rn, [15:12]=Rd, [11:0]=imm[11:0].
  - B: [27:24]=1010, [23:0]=imm[23:0].
- Illegal requests:
  - class 6 or 7;
  - DP op > 3;
  - MUL op > 2;
  - DP-imm with imm[23:8] ≠ 0;
  - LDR/STR with imm[23:12] ≠ 0.
- Pipeline: a single output register (valid bit plus addr plus word).
  - in_ready = !start && (!mem_we || mem_ready).
  - An accepted legal request loads the register on the next edge; mem_we rises that edge.
  - The register advances when mem_we && mem_ready. The write pointer increments by 1 modulo 2^ADDR_W on that handshake, and word_cnt increments unless it is all-ones.
- Control FSM:
  - IDLE (mem_we=0) → on accept → BUSY.
  - BUSY → on handshake with no new accept → IDLE.
  - BUSY → on handshake plus accept → stays BUSY (back-to-back, full throughput).
  - BUSY → on mem_ready=0 → stays BUSY with addr and wdata stable.
- start while a word is pending: the pending word is discarded (mem_we drops next cycle), the pointer loads start_addr, word_cnt=0, err=0. No request is accepted in the start cycle.
- Reset mid-write: the pending word is discarded, with no partial write.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=BASE_RST, mem_wdata=0, word_cnt=0, err=0, FSM=IDLE.
- Latency: 1 cycle from accept to mem_we.
- Throughput: 1 word per cycle while mem_ready=1.
- mem_addr and mem_wdata must not change while mem_we=1 and mem_ready=0.
- err asserts the cycle after an illegal request is accepted.
- Wrap-around: after a write at 2^ADDR_W−1, the next address is 0.

## Configuration
- INSTR_ENC_CHECK_EN defined: an illegal request is accepted (handshake completes) but dropped, with no write, and err is set.
- INSTR_ENC_CHECK_EN undefined: no checking. err is tied to 0, out-of-range fields are truncated to their encoded width, and class 6/7 encodes as word 0x00000000 and is written.

## Test plan
- Reset, then DP-reg ADD cond=E, S=0, Rd=2, Rn=3, Rm=4 → mem_we next cycle, addr=0, wdata=0xE0832004.
- DP-imm SUB S=1, Rd=1, Rn=1, imm=5, then LDR Rd=5, Rn=0, imm=0x10, then B imm=0xFFFFFE, all back-to-back with mem_ready=1 → consecutive words at addrs 0, 1, 2: 0xE2511005, 0xE5905010, 0xEAFFFFFE; word_cnt=3.
- UMULL Rd=7, Ra=6, Rm=2, Rn=1 with mem_ready held low for 3 cycles → wdata=0xE0876291 stable; in_ready=0; addr unchanged until release.
- start_addr=2^ADDR_W−1 followed by two STR writes → addresses 2^ADDR_W−1 then 0.
- With INSTR_ENC_CHECK_EN defined, DP-imm with imm=0x100 → no mem_we, err=1; a following start clears err.
- Assert start while mem_we=1 and mem_ready=0 → word dropped, addr=start_addr, word_cnt=0.
